led_frame_buffer: RTL

Double-buffered pixel store sitting directly upstream of the HUB75 scan driver (`LED_top`) for the 32×32 RGB matrix. A pattern source writes 3-bit RGB pixels into the back bank, while the scan driver reads row-pair data (`{R0,G0,B0,R1,G1,B1}`) from the front bank. Banks swap only at a scan-driver frame boundary, so the panel never shows a torn frame. A hardware clear sequencer zero-fills the back bank on request.

---
 rtl/led_frame_buffer_if.sv | 33 +++
 rtl/led_frame_buffer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/led_frame_buffer_if.sv
// Pixel-write, control and scan-read signal bundle between a pattern source / scan driver
// and led_frame_buffer.
interface led_frame_buffer_if #(
    parameter int unsigned XW = 5,
    parameter int unsigned YW = 5
);
    logic          wr_en;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;
    logic [2:0]    wr_rgb;
    logic          clr_req;
    logic          swap_req;
    logic          frame_end;
    logic          rd_en;
    logic [YW-2:0] rd_row;
    logic [XW-1:0] rd_col;
    logic [5:0]    rd_data;
    logic          rd_valid;
    logic          busy;
    logic          swap_pending;
    logic          swap_done;
    logic          front;

    modport master (
        output wr_en, wr_x, wr_y, wr_rgb, clr_req, swap_req, frame_end, rd_en, rd_row, rd_col,
        input  rd_data, rd_valid, busy, swap_pending, swap_done, front
    );

    modport slave (
        input  wr_en, wr_x, wr_y, wr_rgb, clr_req, swap_req, frame_end, rd_en, rd_row, rd_col,
        output rd_data, rd_valid, busy, swap_pending, swap_done, front
    );
endinterface

// File: rtl/led_frame_buffer.sv
// Double-buffered 3-bit RGB frame store for a HUB75 panel: back-bank writes, front-bank
// row-pair reads, frame-boundary bank swap and a hardware zero-fill sequencer.
module led_frame_buffer #(
    parameter int unsigned COLS = 32,
    parameter int unsigned ROWS = 32,
    parameter int unsigned XW   = 5,
    parameter int unsigned YW   = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    led_frame_buffer_if.slave bus
);
    localparam int unsigned    AW       = XW + YW;
    localparam int unsigned    Depth    = ROWS * COLS;
    localparam logic [AW-1:0]  LastAddr = AW'(ROWS * COLS - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e        r_state, w_state_d;
    logic [AW-1:0] r_cnt, w_cnt_d;
    logic          r_front;
    logic          r_swap_pending;
    logic          r_swap_done;
    logic          r_rd_valid;
    logic [5:0]    r_rd_data;

    // Top and bottom panel halves live in separate arrays so one read serves a row pair.
    // Each array holds both banks, addressed {bank, row, col}.
    logic [2:0]    r_mem_hi [Depth];
    logic [2:0]    r_mem_lo [Depth];

    logic          w_idle;
    logic          w_swap;
    logic          w_we;
    logic          w_wr_half;
    logic [YW-2:0] w_wr_row;
    logic [XW-1:0] w_wr_col;
    logic [2:0]    w_wr_data;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;

    assign w_idle = (r_state == StIdle);
    assign w_swap = bus.frame_end & (r_swap_pending | bus.swap_req) & w_idle;

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (bus.clr_req) begin
                    w_state_d = StClear;
                    w_cnt_d   = '0;
                end
            end
            StClear: begin
                w_cnt_d = r_cnt + 1'b1;
                if (r_cnt == LastAddr) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_we      = 1'b0;
        w_wr_half = 1'b0;
        w_wr_row  = '0;
        w_wr_col  = '0;
        w_wr_data = '0;
        if (r_state == StClear) begin
            w_we      = 1'b1;
            w_wr_half = r_cnt[AW-1];
            w_wr_row  = r_cnt[AW-2:XW];
            w_wr_col  = r_cnt[XW-1:0];
        end else if (bus.wr_en) begin
            w_we      = 1'b1;
            w_wr_half = bus.wr_y[YW-1];
            w_wr_row  = bus.wr_y[YW-2:0];
            w_wr_col  = bus.wr_x;
            w_wr_data = bus.wr_rgb;
        end
    end

    // Both ports use the pre-swap bank index, so a swap-cycle write lands in the bank
    // that is about to be displayed and a swap-cycle read still sees the old front.
    assign w_wr_addr = {~r_front, w_wr_row, w_wr_col};
    assign w_rd_addr = {r_front, bus.rd_row, bus.rd_col};

    always_ff @(posedge i_clk) begin
        if (w_we && !w_wr_half) begin
            r_mem_hi[w_wr_addr] <= w_wr_data;
        end
        if (w_we && w_wr_half) begin
            r_mem_lo[w_wr_addr] <= w_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= StIdle;
            r_cnt          <= '0;
            r_front        <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_done    <= 1'b0;
            r_rd_valid     <= 1'b0;
            r_rd_data      <= '0;
        end else begin
            r_state     <= w_state_d;
            r_cnt       <= w_cnt_d;
            r_swap_done <= w_swap;
            r_rd_valid  <= bus.rd_en;
            if (w_swap) begin
                r_front        <= ~r_front;
                r_swap_pending <= 1'b0;
            end else if (bus.swap_req) begin
                r_swap_pending <= 1'b1;
            end
            if (bus.rd_en) begin
                r_rd_data <= {r_mem_hi[w_rd_addr], r_mem_lo[w_rd_addr]};
            end
        end
    end

    assign bus.rd_data      = r_rd_data;
    assign bus.rd_valid     = r_rd_valid;
    assign bus.busy         = (r_state == StClear);
    assign bus.swap_pending = r_swap_pending;
    assign bus.swap_done    = r_swap_done;
    assign bus.front        = r_front;
endmodule
